// File: rtl/cart_pkg.sv
// Shared cartridge-memory types: mode codes, arbiter states and the memory request payload.
package cart_pkg;

  localparam int unsigned ADDR_W   = 25;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BE_W     = 2;
  localparam int unsigned MODE_W   = 3;
  localparam int unsigned STREAK_W = 4;

  localparam logic [MODE_W-1:0] CART_NONE     = 3'd0;
  localparam logic [MODE_W-1:0] CART_ROM2M    = 3'd1;
  localparam logic [MODE_W-1:0] CART_DRAM1M   = 3'd2;
  localparam logic [MODE_W-1:0] CART_DRAM4M   = 3'd3;
  localparam logic [MODE_W-1:0] CART_BACKUP   = 3'd4;
  localparam logic [MODE_W-1:0] CART_ROM_ACS1 = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY_C, BUSY_H, DONE} arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              wr;
    logic              rd;
  } mem_req_t;

  function automatic logic req_present(input logic [BE_W-1:0] we, input logic rd);
    return (we != '0) || rd;
  endfunction

  // A request with any byte enable set is a write; RD is then ignored.
  function automatic mem_req_t make_req(input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d,
                                        input logic [BE_W-1:0]   we);
    mem_req_t r;
    r.addr = a;
    r.data = d;
    r.wr   = (we != '0);
    r.rd   = (we == '0);
    r.be   = r.wr ? we : '1;
    return r;
  endfunction

endpackage

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge memory port between the A-bus cart controller and the HPS loader,
// cart first with a streak limit that guarantees HPS progress.
module cart_mem_arbiter
  import cart_pkg::*;
#(
  parameter int unsigned MAX_CART_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [MODE_W-1:0] MODE,
  input  logic [ADDR_W:1]   CART_A,
  input  logic [DATA_W-1:0] CART_DO,
  input  logic [BE_W-1:0]   CART_WE,
  input  logic              CART_RD,
  output logic [DATA_W-1:0] CART_DI,
  output logic              CART_RDY,
  input  logic [ADDR_W:1]   HPS_A,
  input  logic [DATA_W-1:0] HPS_DO,
  input  logic [BE_W-1:0]   HPS_WE,
  input  logic              HPS_RD,
  output logic [DATA_W-1:0] HPS_DI,
  output logic              HPS_RDY,
  output logic [ADDR_W:1]   DDR_A,
  output logic [DATA_W-1:0] DDR_DO,
  output logic [BE_W-1:0]   DDR_BE,
  output logic              DDR_WR,
  output logic              DDR_RD,
  input  logic [DATA_W-1:0] DDR_DI,
  input  logic              DDR_ACK,
  output logic              GNT_HPS
);

  arb_state_t          state, state_d;
  logic [STREAK_W-1:0] streak, streak_d;
  mem_req_t            ddr_q, ddr_d;
  logic [DATA_W-1:0]   cart_di_q, cart_di_d, hps_di_q, hps_di_d;
  logic                cart_rdy_q, cart_rdy_d, hps_rdy_q, hps_rdy_d;
  logic                gnt_hps_q, gnt_hps_d;

  logic cart_req, hps_req, cart_wr, streak_max, hps_win, cart_win, cart_local;

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    cart_req   = req_present(CART_WE, CART_RD);
    hps_req    = req_present(HPS_WE, HPS_RD);
    cart_wr    = (CART_WE != '0);
    streak_max = (streak == STREAK_W'(MAX_CART_STREAK));
    hps_win    = hps_req && (!cart_req || streak_max);
    cart_win   = cart_req && !hps_win;
    cart_local = (MODE == CART_NONE) ||
                 (cart_wr && ((MODE == CART_ROM2M) || (MODE == CART_ROM_ACS1)));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    streak_d   = streak;
    ddr_d      = ddr_q;
    cart_di_d  = cart_di_q;
    hps_di_d   = hps_di_q;
    cart_rdy_d = 1'b0;
    hps_rdy_d  = 1'b0;
    gnt_hps_d  = gnt_hps_q;

    case (state)
      IDLE: begin
        if (!hps_req) streak_d = '0;
        if (hps_win) begin
          state_d   = BUSY_H;
          streak_d  = '0;
          ddr_d     = make_req(HPS_A, HPS_DO, HPS_WE);
          gnt_hps_d = 1'b1;
        end else if (cart_win) begin
          if (hps_req && !streak_max) streak_d = streak + STREAK_W'(1);
          if (cart_local) begin
            // Forbidden or unmapped access: finish without touching memory
            state_d    = DONE;
            cart_rdy_d = 1'b1;
            if (MODE == CART_NONE) cart_di_d = 16'hFFFF;
          end else begin
            state_d = BUSY_C;
            ddr_d   = make_req(CART_A, CART_DO, CART_WE);
          end
        end
      end
      BUSY_C: begin
        if (DDR_ACK) begin
          state_d    = DONE;
          ddr_d.wr   = 1'b0;
          ddr_d.rd   = 1'b0;
          cart_rdy_d = 1'b1;
          if (ddr_q.rd) cart_di_d = DDR_DI;
        end
      end
      BUSY_H: begin
        if (DDR_ACK) begin
          state_d   = DONE;
          ddr_d.wr  = 1'b0;
          ddr_d.rd  = 1'b0;
          hps_rdy_d = 1'b1;
          gnt_hps_d = 1'b0;
          if (ddr_q.rd) hps_di_d = DDR_DI;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      streak     <= '0;
      ddr_q      <= '0;
      cart_di_q  <= '0;
      hps_di_q   <= '0;
      cart_rdy_q <= 1'b0;
      hps_rdy_q  <= 1'b0;
      gnt_hps_q  <= 1'b0;
    end else begin
      state      <= state_d;
      streak     <= streak_d;
      ddr_q      <= ddr_d;
      cart_di_q  <= cart_di_d;
      hps_di_q   <= hps_di_d;
      cart_rdy_q <= cart_rdy_d;
      hps_rdy_q  <= hps_rdy_d;
      gnt_hps_q  <= gnt_hps_d;
    end
  end

  assign DDR_A    = ddr_q.addr;
  assign DDR_DO   = ddr_q.data;
  assign DDR_BE   = ddr_q.be;
  assign DDR_WR   = ddr_q.wr;
  assign DDR_RD   = ddr_q.rd;
  assign CART_DI  = cart_di_q;
  assign HPS_DI   = hps_di_q;
  assign CART_RDY = cart_rdy_q;
  assign HPS_RDY  = hps_rdy_q;
  assign GNT_HPS  = gnt_hps_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter: a table of single transactions plus
// hand-written arbitration, streak, reset and hold-through-RDY sequences.
module tb_cart_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  MODE = 3'd0;
  logic [25:1] CART_A = '0;
  logic [15:0] CART_DO = '0;
  logic [1:0]  CART_WE = '0;
  logic        CART_RD = 1'b0;
  logic [15:0] CART_DI;
  logic        CART_RDY;
  logic [25:1] HPS_A = '0;
  logic [15:0] HPS_DO = '0;
  logic [1:0]  HPS_WE = '0;
  logic        HPS_RD = 1'b0;
  logic [15:0] HPS_DI;
  logic        HPS_RDY;
  logic [25:1] DDR_A;
  logic [15:0] DDR_DO;
  logic [1:0]  DDR_BE;
  logic        DDR_WR;
  logic        DDR_RD;
  logic [15:0] DDR_DI = '0;
  logic        GNT_HPS;
  logic        ack_man = 1'b0;
  logic        ack_auto = 1'b0;
  logic        auto_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ddr_txn = 0;
  logic req_prev = 1'b0;
  logic grant_log[$];

  cart_mem_arbiter #(.MAX_CART_STREAK(4)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE),
    .CART_A(CART_A), .CART_DO(CART_DO), .CART_WE(CART_WE), .CART_RD(CART_RD),
    .CART_DI(CART_DI), .CART_RDY(CART_RDY),
    .HPS_A(HPS_A), .HPS_DO(HPS_DO), .HPS_WE(HPS_WE), .HPS_RD(HPS_RD),
    .HPS_DI(HPS_DI), .HPS_RDY(HPS_RDY),
    .DDR_A(DDR_A), .DDR_DO(DDR_DO), .DDR_BE(DDR_BE), .DDR_WR(DDR_WR), .DDR_RD(DDR_RD),
    .DDR_DI(DDR_DI), .DDR_ACK(ack_man | ack_auto), .GNT_HPS(GNT_HPS)
  );

  always #5 CLK = ~CLK;

  // Minimum-latency memory model: ack in the first cycle a request is visible
  always @(negedge CLK) begin
    if (auto_en && (DDR_RD || DDR_WR) && !ack_auto) ack_auto = 1'b1;
    else ack_auto = 1'b0;
  end

  // Log each new DDR access and who owned it (1 = HPS)
  always @(negedge CLK) begin
    if ((DDR_RD || DDR_WR) && !req_prev) begin
      ddr_txn = ddr_txn + 1;
      grant_log.push_back(GNT_HPS);
    end
    req_prev = DDR_RD || DDR_WR;
  end

  typedef struct {
    logic [2:0]  mode;
    logic        is_hps;
    logic [1:0]  we;
    logic        rd;
    logic [24:0] a;
    logic [15:0] dout;
    int          ack_dly;
    logic [15:0] ddr_di;
    logic        exp_ddr;
    logic [1:0]  exp_be;
    logic [15:0] exp_di;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_reqs();
    CART_WE = '0; CART_RD = 1'b0; HPS_WE = '0; HPS_RD = 1'b0;
  endtask

  // One complete transaction; the requester holds its request through its RDY cycle
  task automatic run_txn(input vec_t v);
    MODE = v.mode;
    if (v.is_hps) begin
      HPS_A = v.a; HPS_DO = v.dout; HPS_WE = v.we; HPS_RD = v.rd;
    end else begin
      CART_A = v.a; CART_DO = v.dout; CART_WE = v.we; CART_RD = v.rd;
    end
    step();
    if (v.exp_ddr) begin
      chk("grant_wr", DDR_WR, (v.we != 2'b00));
      chk("grant_rd", DDR_RD, (v.we == 2'b00));
      chk("grant_be", DDR_BE, v.exp_be);
      chk("grant_a", DDR_A, v.a);
      if (v.we != 2'b00) chk("grant_do", DDR_DO, v.dout);
      chk("grant_gnt_hps", GNT_HPS, v.is_hps);
      for (int i = 0; i < v.ack_dly; i++) begin
        step();
        chk("wait_no_rdy", CART_RDY | HPS_RDY, 0);
      end
      DDR_DI = v.ddr_di;
      ack_man = 1'b1;
      step();
      ack_man = 1'b0;
      chk("ack_ddr_drop", DDR_WR | DDR_RD, 0);
      chk("ack_gnt_drop", GNT_HPS, 0);
    end else begin
      chk("local_no_ddr", DDR_WR | DDR_RD, 0);
    end
    chk("rdy", v.is_hps ? HPS_RDY : CART_RDY, 1);
    chk("other_rdy", v.is_hps ? CART_RDY : HPS_RDY, 0);
    chk("di", v.is_hps ? HPS_DI : CART_DI, v.exp_di);
    step();
    chk("rdy_width", CART_RDY | HPS_RDY, 0);
    clear_reqs();
    step();
  endtask

  vec_t vecs[13];
  vec_t hv;
  int   base, base_t;
  logic hps_done;
  logic [6:0] exp_seq;

  initial begin
    //        mode  hps   we     rd    a              dout      dly ddr_di    ddr   be     exp_di
    vecs[0]  = '{3'd3, 1'b0, 2'b00, 1'b1, 25'h0000010,   16'h0000, 3, 16'hBEEF, 1'b1, 2'b11, 16'hBEEF};
    vecs[1]  = '{3'd3, 1'b0, 2'b01, 1'b0, 25'h0000123,   16'h55AA, 0, 16'h1111, 1'b1, 2'b01, 16'hBEEF};
    vecs[2]  = '{3'd1, 1'b0, 2'b11, 1'b0, 25'h0000040,   16'hDEAD, 0, 16'h2222, 1'b0, 2'b00, 16'hBEEF};
    vecs[3]  = '{3'd0, 1'b0, 2'b00, 1'b1, 25'h0000020,   16'h0000, 0, 16'h3333, 1'b0, 2'b00, 16'hFFFF};
    vecs[4]  = '{3'd1, 1'b0, 2'b00, 1'b1, 25'h0000200,   16'h0000, 1, 16'h1234, 1'b1, 2'b11, 16'h1234};
    vecs[5]  = '{3'd5, 1'b0, 2'b10, 1'b0, 25'h0000044,   16'hABCD, 0, 16'h4444, 1'b0, 2'b00, 16'h1234};
    vecs[6]  = '{3'd0, 1'b0, 2'b11, 1'b0, 25'h0000048,   16'h5555, 0, 16'h5555, 1'b0, 2'b00, 16'hFFFF};
    vecs[7]  = '{3'd5, 1'b0, 2'b00, 1'b1, 25'h1FFFFFF,   16'h0000, 2, 16'h8001, 1'b1, 2'b11, 16'h8001};
    vecs[8]  = '{3'd0, 1'b1, 2'b00, 1'b1, 25'h1FFFFFF,   16'h0000, 2, 16'hCAFE, 1'b1, 2'b11, 16'hCAFE};
    vecs[9]  = '{3'd0, 1'b1, 2'b10, 1'b0, 25'h0000777,   16'hA5A5, 0, 16'h9999, 1'b1, 2'b10, 16'hCAFE};
    vecs[10] = '{3'd4, 1'b0, 2'b11, 1'b1, 25'h0000000,   16'h0102, 0, 16'h7777, 1'b1, 2'b11, 16'h8001};
    vecs[11] = '{3'd2, 1'b0, 2'b00, 1'b1, 25'h0000155,   16'h0000, 5, 16'h0F0F, 1'b1, 2'b11, 16'h0F0F};
    vecs[12] = '{3'd1, 1'b1, 2'b01, 1'b0, 25'h0000003,   16'h4242, 1, 16'h6666, 1'b1, 2'b01, 16'hCAFE};

    // Reset state
    #2;
    chk("rst_ddr_req", {30'd0, DDR_WR, DDR_RD}, 0);
    chk("rst_rdy_gnt", {29'd0, CART_RDY, HPS_RDY, GNT_HPS}, 0);
    chk("rst_ddr_a", DDR_A, 0);
    chk("rst_ddr_do_be", {14'd0, DDR_DO, DDR_BE}, 0);
    chk("rst_di", {CART_DI, HPS_DI}, 0);
    step(); step();
    RST = 1'b0;
    step();

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // Simultaneous cart write and HPS read: cart first, HPS after DONE
    MODE = 3'd3;
    CART_A = 25'h50; CART_DO = 16'h00C3; CART_WE = 2'b01;
    HPS_A = 25'h60; HPS_RD = 1'b1;
    step();
    chk("arb_cart_wr", DDR_WR, 1);
    chk("arb_cart_be", DDR_BE, 2'b01);
    chk("arb_cart_a", DDR_A, 25'h50);
    chk("arb_gnt_cart", GNT_HPS, 0);
    ack_man = 1'b1; step(); ack_man = 1'b0;
    chk("arb_cart_rdy", CART_RDY, 1);
    chk("arb_hps_waits", HPS_RDY, 0);
    step();
    CART_WE = 2'b00;
    step();
    chk("arb_hps_rd", DDR_RD, 1);
    chk("arb_hps_a", DDR_A, 25'h60);
    chk("arb_gnt_hps", GNT_HPS, 1);
    step();
    chk("arb_gnt_hold", GNT_HPS, 1);
    DDR_DI = 16'h7777;
    ack_man = 1'b1; step(); ack_man = 1'b0;
    chk("arb_hps_rdy", HPS_RDY, 1);
    chk("arb_hps_di", HPS_DI, 16'h7777);
    chk("arb_gnt_off", GNT_HPS, 0);
    step();
    HPS_RD = 1'b0;
    step();

    // A cart read held through its RDY cycle produces exactly one DDR access
    base_t = ddr_txn;
    MODE = 3'd3; CART_A = 25'h88; CART_RD = 1'b1;
    step(); step();
    DDR_DI = 16'h1357;
    ack_man = 1'b1; step(); ack_man = 1'b0;
    chk("hold_rdy", CART_RDY, 1);
    chk("hold_di", CART_DI, 16'h1357);
    step();
    chk("hold_rdy_width", CART_RDY, 0);
    CART_RD = 1'b0;
    step(); step();
    chk("hold_one_txn", 32'(ddr_txn - base_t), 1);
    chk("hold_no_reissue", DDR_RD, 0);

    // Streak guard: continuous cart reads with an HPS read pending
    base = grant_log.size();
    hps_done = 1'b0;
    MODE = 3'd3; CART_A = 25'h300; CART_RD = 1'b1;
    HPS_A = 25'h400; HPS_RD = 1'b1;
    auto_en = 1'b1;
    for (int c = 0; c < 80 && !(hps_done && (grant_log.size() >= base + 7)); c++) begin
      step();
      if (HPS_RDY) begin
        step();
        HPS_RD = 1'b0;
        hps_done = 1'b1;
      end
    end
    for (int c = 0; c < 10 && !CART_RDY; c++) step();
    step();
    CART_RD = 1'b0;
    step(); step();
    auto_en = 1'b0;
    chk("streak_hps_done", hps_done, 1);
    chk("streak_min_grants", (grant_log.size() >= base + 7), 1);
    exp_seq = 7'b0010000;
    if (grant_log.size() >= base + 7)
      for (int i = 0; i < 7; i++) chk($sformatf("streak_grant%0d", i), grant_log[base + i], exp_seq[i]);

    // Reset in the middle of an HPS access; the late ack must be ignored
    MODE = 3'd3; HPS_A = 25'h0ABCDE; HPS_RD = 1'b1;
    step();
    chk("rstm_busy", {30'd0, GNT_HPS, DDR_RD}, 3);
    RST = 1'b1;
    #1;
    chk("rstm_ddr_req", {30'd0, DDR_WR, DDR_RD}, 0);
    chk("rstm_gnt", GNT_HPS, 0);
    chk("rstm_ddr_a", DDR_A, 0);
    chk("rstm_di", {CART_DI, HPS_DI}, 0);
    HPS_RD = 1'b0;
    step();
    RST = 1'b0;
    step();
    ack_man = 1'b1; step(); ack_man = 1'b0;
    chk("rstm_late_ack_rdy", HPS_RDY, 0);
    chk("rstm_late_ack_ddr", DDR_RD, 0);
    step();
    chk("rstm_late_ack_rdy2", HPS_RDY, 0);
    hv = '{3'd3, 1'b1, 2'b00, 1'b1, 25'h0ABCDE, 16'h0000, 1, 16'h2468, 1'b1, 2'b11, 16'h2468};
    run_txn(hv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
